// File: rtl/entry_alloc_pkg.sv
// Shared processor parameters and helpers for the entry allocator.
package entry_alloc_pkg;

  localparam int unsigned NUM_ENTRIES = 32;
  localparam int unsigned IDX_W       = 5;

  typedef logic [IDX_W-1:0] entry_idx_t;

  // Number of set bits in a two-bit strobe vector.
  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/entry_alloc_prien.sv
// Low/high priority encoder: lowest and highest set bit of a vector.
module entry_alloc_prien #(
  parameter int unsigned DE_SIZE = 32,
  parameter int unsigned EN_SIZE = 5
) (
  input  logic [DE_SIZE-1:0] de,
  output logic [EN_SIZE-1:0] lo_idx_c,
  output logic [EN_SIZE-1:0] hi_idx_c,
  output logic               any_c
);

  // Scan both directions; the last hit in each loop wins.
  always_comb begin
    lo_idx_c = '0;
    hi_idx_c = '0;
    any_c    = |de;
    for (int i = int'(DE_SIZE) - 1; i >= 0; i--) begin
      if (de[i]) lo_idx_c = EN_SIZE'(i);
    end
    for (int i = 0; i < int'(DE_SIZE); i++) begin
      if (de[i]) hi_idx_c = EN_SIZE'(i);
    end
  end

endmodule

// File: rtl/entry_alloc.sv
// Two-slot free-list allocator over a bitmap of tracked entries.
module entry_alloc #(
  parameter int unsigned NUM_ENTRIES = entry_alloc_pkg::NUM_ENTRIES,
  parameter int unsigned IDX_W       = entry_alloc_pkg::IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       alloc_req,
  input  logic [1:0]       free_en,
  input  logic [IDX_W-1:0] free_idx0,
  input  logic [IDX_W-1:0] free_idx1,
  output logic [IDX_W-1:0] alloc_idx_a,
  output logic [IDX_W-1:0] alloc_idx_b,
  output logic [1:0]       alloc_gnt,
  output logic [IDX_W:0]   free_count,
  output logic             stall,
  output logic             err
);

  import entry_alloc_pkg::pop2;

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [NUM_ENTRIES-1:0] free_map;
  logic [NUM_ENTRIES-1:0] alloc_mask;
  logic [NUM_ENTRIES-1:0] free_mask;
  logic                   any_free;
  logic [1:0]             free_vld;
  logic                   same_idx;
  logic                   dbl_free;
  logic                   bad_req;

  entry_alloc_prien #(
    .DE_SIZE (NUM_ENTRIES),
    .EN_SIZE (IDX_W)
  ) prien (
    .de       (free_map),
    .lo_idx_c (alloc_idx_a),
    .hi_idx_c (alloc_idx_b),
    .any_c    (any_free)
  );

  // Zero-latency grants; slot B only when two distinct entries exist.
  always_comb begin
    alloc_gnt    = '0;
    alloc_gnt[0] = alloc_req[0] & any_free;
    alloc_gnt[1] = alloc_req[1] & alloc_gnt[0] & (free_count >= CNT_W'(2));
    stall        = (alloc_req[0] & (free_count == '0)) |
                   (alloc_req[1] & (free_count < CNT_W'(2)));
  end

  // Qualify frees: only allocated entries count, a shared index counts once.
  always_comb begin
    same_idx    = &free_en & (free_idx0 == free_idx1);
    free_vld    = '0;
    free_vld[0] = free_en[0] & ~free_map[free_idx0];
    free_vld[1] = free_en[1] & ~free_map[free_idx1] & ~same_idx;
    dbl_free    = (free_en[0] & free_map[free_idx0]) |
                  (free_en[1] & free_map[free_idx1]) | same_idx;
    bad_req     = (alloc_req == 2'b10);
  end

  // One-hot masks of entries leaving and re-entering the free set.
  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    if (alloc_gnt[0]) alloc_mask[alloc_idx_a] = 1'b1;
    if (alloc_gnt[1]) alloc_mask[alloc_idx_b] = 1'b1;
    if (free_vld[0])  free_mask[free_idx0]    = 1'b1;
    if (free_vld[1])  free_mask[free_idx1]    = 1'b1;
  end

  // Bitmap, counter and sticky error; frees become visible next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_map   <= '1;
      free_count <= CNT_W'(NUM_ENTRIES);
      err        <= 1'b0;
    end else begin
      free_map   <= (free_map & ~alloc_mask) | free_mask;
      free_count <= free_count - CNT_W'(pop2(alloc_gnt)) + CNT_W'(pop2(free_vld));
      if (dbl_free | bad_req) err <= 1'b1;
    end
  end

endmodule

// File: doc/entry_alloc.md
ENTRY_ALLOC -- requirements
Module: entry_alloc

Interface
REQ-001 Parameter NUM_ENTRIES, default 32, number of tracked entries (e.g. RS or ROB slots).
REQ-002 Parameter IDX_W, default 5, index width, equal to log2(NUM_ENTRIES).
REQ-003 Port clock, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1; reset is synchronous and active-high.
REQ-005 Port alloc_req, input, 2; bit0 = request slot A, bit1 = request slot B; bit1 without bit0 is illegal.
REQ-006 Port free_en, input, 2; per-port release strobe.
REQ-007 Port free_idx0 and free_idx1, input, IDX_W each; entry released on the matching free_en bit.
REQ-008 Port alloc_idx_a, output, IDX_W; lowest free index.
REQ-009 Port alloc_idx_b, output, IDX_W; highest free index.
REQ-010 Port alloc_gnt, output, 2; bit0 = slot A granted, bit1 = slot B granted.
REQ-011 Port free_count, output, IDX_W+1; number of free entries.
REQ-012 Port stall, output, 1; requested count exceeds free_count.
REQ-013 Port err, output, 1; sticky protocol-error flag.

Function
REQ-014 State is a NUM_ENTRIES-bit free bitmap (1 = free), a free_count register and the err register.
REQ-015 alloc_idx_a and alloc_idx_b are combinational from the registered bitmap, via the low/high priority encoder; zero-latency grant.
REQ-016 alloc_gnt[0] = alloc_req[0] and bitmap nonzero.
REQ-017 alloc_gnt[1] = alloc_req[1] and alloc_gnt[0] and free_count >= 2, which guarantees alloc_idx_a != alloc_idx_b.
REQ-018 stall = (alloc_req[0] and free_count == 0) or (alloc_req[1] and free_count < 2); any grants still issued remain valid.
REQ-019 On the clock edge, granted indices are cleared in the bitmap; indices with free_en set are set in the bitmap.
REQ-020 Frees are not bypassed: a freed entry becomes allocatable the cycle after free_en.
REQ-021 next free_count = free_count - popcount(alloc_gnt) + number of valid frees; the width never overflows.
REQ-022 Double free (free_en on an entry already free, or both ports on the same index) sets err.
REQ-023 A double free leaves the bitmap bit set and counts the entry once.
REQ-024 Illegal alloc_req = 2'b10 sets err and grants nothing.
REQ-025 Full state (free_count 0): no grants, stall on any request; one free alone restores allocation the next cycle.
REQ-026 All-free state: alloc_idx_a = 0 and alloc_idx_b = NUM_ENTRIES-1.
REQ-027 Exactly one free entry: alloc_idx_a = alloc_idx_b, and only slot A is grantable.

Reset
REQ-028 While reset is high at a rising edge, the bitmap is set to all ones.
REQ-029 Reset sets free_count to NUM_ENTRIES and clears err.
REQ-030 Reset overrides same-cycle allocs and frees, including mid-operation.
REQ-031 Outputs after reset: alloc_idx_a 0, alloc_idx_b 31, alloc_gnt 0 when no request, stall 0.

Structure
REQ-032 NUM_ENTRIES, IDX_W and the shared entry-index type live in the shared processor parameter package.
REQ-033 The low/high index search is one instantiated sub-module, prien (DE_SIZE = NUM_ENTRIES, EN_SIZE = IDX_W).
REQ-034 entry_alloc holds only the bitmap, counter, grant logic and error logic.

Verification
REQ-035 Reset, then alloc_req 2'b11 -> grant 2'b11, idx_a 0, idx_b 31; next cycle free_count 30, idx_a 1, idx_b 30.
REQ-036 Drain to 1 free entry (index 7), then alloc_req 2'b11 -> gnt 2'b01, idx_a = idx_b = 7, stall 1; next cycle free_count 0.
REQ-037 Full, then free_en 2'b01 with idx 12 and alloc_req 2'b01 in the same cycle -> gnt 0, stall 1; next cycle idx_a = 12, gnt 2'b01.
REQ-038 Cycle with gnt 2'b11 plus free_en 2'b11 of two allocated indices -> free_count unchanged next cycle; bitmap matches the reference model.
REQ-039 Free of an already-free index 3, then separately alloc_req 2'b10 -> err set and held; free_count unchanged; reset clears err.
REQ-040 Random 10k-cycle alloc/free traffic against a scoreboard: grants never duplicate a live index, and free_count always equals the bitmap popcount.
